cut_dat_packer: RTL and testbench

Downstream neighbour of the cut-data stage. Takes the trimmed 16-bit word stream (en_in/dat_in), packs four words into one 64-bit word and groups the 64-bit words into fixed-length sectors for the SSD write FIFO. On stop, it pads the open sector to its full length, so the SSD side only ever sees whole sectors. It reports progress (sector count) and overflow to the control logic.

---
 rtl/cut_pack_pkg.sv | 18 +
 rtl/cut_dat_packer_edge_sync.sv | 24 ++
 rtl/cut_dat_packer.sv | 193 +++++++++++++++++++
 tb/tb_cut_dat_packer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cut_pack_pkg.sv
// Shared types and constants for the cut-data packer: FSM states, lane/word counter sizing
// and the reserved field of the optional sector header.
package cut_pack_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam int LANE_W = 2;
    localparam logic [15:0] HDR_RSVD = 16'h0000;

    function automatic int word_cnt_width(input int sector_words);
        return (sector_words > 1) ? $clog2(sector_words) : 1;
    endfunction

endpackage

// File: rtl/cut_dat_packer_edge_sync.sv
// Two-flop synchroniser for a level control input with a one-cycle rising-edge pulse output.
module edge_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic i_din,
    output logic o_rise
);

    logic r_reg0;
    logic r_reg1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_reg0 <= 1'b0;
            r_reg1 <= 1'b0;
        end else begin
            r_reg0 <= i_din;
            r_reg1 <= r_reg0;
        end
    end

    assign o_rise = r_reg0 & ~r_reg1;

endmodule

// File: rtl/cut_dat_packer.sv
// Packs 16-bit cut-stage words into 64-bit words grouped in padded fixed-length sectors.
// Define CUT_PACK_HDR_EN to place a {HDR_SYNC, 0, sector_cnt} header in slot 0 of each sector.
module cut_dat_packer
    import cut_pack_pkg::*;
#(
    parameter int          SECTOR_WORDS = 64,
    parameter logic [15:0] PAD_WORD     = 16'hFFFF,
    parameter logic [15:0] HDR_SYNC     = 16'hEB90
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start_en,
    input  logic        stop_en,
    input  logic        en_in,
    input  logic [15:0] dat_in,
    input  logic        fifo_full,
    output logic        wr_en,
    output logic [63:0] wr_dat,
    output logic        sector_done,
    output logic [31:0] sector_cnt,
    output logic        ovf_flag,
    output logic        busy
);

    localparam int WCW = word_cnt_width(SECTOR_WORDS);
    localparam logic [WCW-1:0] LAST_WORD = WCW'(SECTOR_WORDS - 1);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(3);

    state_t             r_state, w_state_next;
    logic [LANE_W-1:0]  r_lane_cnt, w_lane_cnt_next;
    logic [2:0][15:0]   r_lane, w_lane_next;
    logic [WCW-1:0]     r_word_cnt, w_word_cnt_next;
    logic [31:0]        r_sector_cnt, w_sector_cnt_next;
    logic               r_ovf, w_ovf_next;
    logic               r_wr_en, w_wr_en_next;
    logic [63:0]        r_wr_dat, w_wr_dat_next;
    logic               r_sector_done, w_sector_done_next;

    logic               w_start_rise;
    logic               w_stop_rise;
    logic               w_hdr_pending;
    logic [63:0]        w_hdr_word;
    logic [63:0]        w_pack_word;
    logic [63:0]        w_flush_word;
    logic               w_do_write;
    logic [63:0]        w_write_word;

    edge_sync u_start_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_din   (start_en),
        .o_rise  (w_start_rise)
    );

    edge_sync u_stop_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_din   (stop_en),
        .o_rise  (w_stop_rise)
    );

`ifdef CUT_PACK_HDR_EN
    assign w_hdr_pending = (r_word_cnt == '0);
`else
    assign w_hdr_pending = 1'b0;
`endif

    assign w_hdr_word  = {HDR_SYNC, HDR_RSVD, r_sector_cnt};
    assign w_pack_word = {r_lane[0], r_lane[1], r_lane[2], dat_in};

    // Lanes already filled keep their data; the rest of the open word becomes padding.
    for (genvar gi = 0; gi < 3; gi++) begin : g_flush_lane
        assign w_flush_word[63-16*gi -: 16] = (r_lane_cnt > LANE_W'(gi)) ? r_lane[gi] : PAD_WORD;
    end
    assign w_flush_word[15:0] = PAD_WORD;

    always_comb begin
        w_state_next       = r_state;
        w_lane_cnt_next    = r_lane_cnt;
        w_lane_next        = r_lane;
        w_word_cnt_next    = r_word_cnt;
        w_sector_cnt_next  = r_sector_cnt;
        w_ovf_next         = r_ovf;
        w_wr_en_next       = 1'b0;
        w_wr_dat_next      = '0;
        w_sector_done_next = 1'b0;
        w_do_write         = 1'b0;
        w_write_word       = '0;

        case (r_state)
            IDLE: begin
                if (w_start_rise) begin
                    w_state_next      = RUN;
                    w_lane_cnt_next   = '0;
                    w_word_cnt_next   = '0;
                    w_sector_cnt_next = '0;
                    w_ovf_next        = 1'b0;
                end
            end
            RUN: begin
                if (w_stop_rise) begin
                    if (r_lane_cnt == '0 && r_word_cnt == '0) begin
                        w_state_next = IDLE;
                    end else begin
                        w_state_next = FLUSH;
                    end
                end else if (en_in) begin
                    if (w_hdr_pending) begin
                        if (fifo_full) begin
                            w_ovf_next = 1'b1;
                        end else begin
                            w_do_write   = 1'b1;
                            w_write_word = w_hdr_word;
                        end
                    end
                    if (r_lane_cnt != LAST_LANE) begin
                        w_lane_next[r_lane_cnt] = dat_in;
                        w_lane_cnt_next         = r_lane_cnt + 1'b1;
                    end else begin
                        w_lane_cnt_next = '0;
                        // A still-pending header owns the single write slot, so the payload word is lost.
                        if (w_hdr_pending || fifo_full) begin
                            w_ovf_next = 1'b1;
                        end else begin
                            w_do_write   = 1'b1;
                            w_write_word = w_pack_word;
                        end
                    end
                end
            end
            FLUSH: begin
                if (r_sector_done) begin
                    w_state_next = IDLE;
                end else if (!fifo_full) begin
                    w_do_write = 1'b1;
                    if (w_hdr_pending) begin
                        w_write_word = w_hdr_word;
                    end else begin
                        w_write_word    = w_flush_word;
                        w_lane_cnt_next = '0;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        if (w_do_write) begin
            w_wr_en_next  = 1'b1;
            w_wr_dat_next = w_write_word;
            if (r_word_cnt == LAST_WORD) begin
                w_word_cnt_next    = '0;
                w_sector_done_next = 1'b1;
                w_sector_cnt_next  = r_sector_cnt + 32'd1;
            end else begin
                w_word_cnt_next = r_word_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_lane_cnt    <= '0;
            r_lane        <= '0;
            r_word_cnt    <= '0;
            r_sector_cnt  <= '0;
            r_ovf         <= 1'b0;
            r_wr_en       <= 1'b0;
            r_wr_dat      <= '0;
            r_sector_done <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_lane_cnt    <= w_lane_cnt_next;
            r_lane        <= w_lane_next;
            r_word_cnt    <= w_word_cnt_next;
            r_sector_cnt  <= w_sector_cnt_next;
            r_ovf         <= w_ovf_next;
            r_wr_en       <= w_wr_en_next;
            r_wr_dat      <= w_wr_dat_next;
            r_sector_done <= w_sector_done_next;
        end
    end

    assign wr_en       = r_wr_en;
    assign wr_dat      = r_wr_dat;
    assign sector_done = r_sector_done;
    assign sector_cnt  = r_sector_cnt;
    assign ovf_flag    = r_ovf;
    assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_cut_dat_packer.sv
// Scoreboard bench for cut_dat_packer: directed sessions push expected writes, a monitor checks them.
module tb_cut_dat_packer;

    localparam int SW = 64;
    localparam logic [63:0] PAD64 = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start_en = 1'b0;
    logic        stop_en = 1'b0;
    logic        en_in = 1'b0;
    logic [15:0] dat_in = 16'h0;
    logic        fifo_full = 1'b0;
    logic        wr_en;
    logic [63:0] wr_dat;
    logic        sector_done;
    logic [31:0] sector_cnt;
    logic        ovf_flag;
    logic        busy;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_writes = 0;
    logic [64:0] exp_q[$];
    logic [64:0] mon_e;

    cut_dat_packer #(
        .SECTOR_WORDS (SW),
        .PAD_WORD     (16'hFFFF),
        .HDR_SYNC     (16'hEB90)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start_en    (start_en),
        .stop_en     (stop_en),
        .en_in       (en_in),
        .dat_in      (dat_in),
        .fifo_full   (fifo_full),
        .wr_en       (wr_en),
        .wr_dat      (wr_dat),
        .sector_done (sector_done),
        .sector_cnt  (sector_cnt),
        .ovf_flag    (ovf_flag),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write is popped against the scoreboard; idle cycles must show zeros.
    always @(negedge clk) begin
        if (reset_n) begin
            if (wr_en) begin
                n_writes++;
                $display("wr %0d: dat=%h done=%0b", n_writes, wr_dat, sector_done);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_write: got %h expected no write", wr_dat);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("wr_dat", wr_dat, mon_e[63:0]);
                    check("sector_done", 64'(sector_done), 64'(mon_e[64]));
                end
            end else begin
                check("idle_wr_dat", wr_dat, 64'h0);
                check("idle_sector_done", 64'(sector_done), 64'h0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [63:0] d, input logic done);
        exp_q.push_back({done, d});
    endtask

    task automatic push_pads(input int n);
        for (int i = 0; i < n; i++) push(PAD64, i == n - 1);
    endtask

    task automatic send(input logic [15:0] v);
        en_in  = 1'b1;
        dat_in = v;
        tick();
        en_in  = 1'b0;
    endtask

    task automatic start_session();
        start_en = 1'b1;
        tick();
        tick();
        start_en = 1'b0;
    endtask

    task automatic stop_session();
        stop_en = 1'b1;
        tick();
        tick();
        stop_en = 1'b0;
    endtask

    // Waits (bounded) for the closing sector_done of a flush, optionally toggling fifo_full every 3 cycles.
    task automatic wait_flush_done(input string name, input bit toggle);
        bit seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (toggle) fifo_full = ((i / 3) % 2 == 0);
            @(negedge clk);
            if (sector_done) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        fifo_full = 1'b0;
        check({name, "_done_seen"}, 64'(seen), 64'h1);
        check({name, "_busy_at_done"}, 64'(busy), 64'h1);
        @(negedge clk);
        check({name, "_busy_after_done"}, 64'(busy), 64'h0);
        tick();
    endtask

    task automatic check_drained(input string name);
        check({name, "_queue_empty"}, 64'(exp_q.size()), 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tick();
        tick();
        check("rst_wr_en", 64'(wr_en), 64'h0);
        check("rst_wr_dat", wr_dat, 64'h0);
        check("rst_sector_done", 64'(sector_done), 64'h0);
        check("rst_sector_cnt", 64'(sector_cnt), 64'h0);
        check("rst_ovf", 64'(ovf_flag), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        reset_n = 1'b1;
        tick();

        // Stop edge in IDLE must not start anything.
        stop_session();
        tick();
        check("idle_stop_busy", 64'(busy), 64'h0);

`ifdef CUT_PACK_HDR_EN
        // Two full sectors with headers, continuous input.
        for (int s = 0; s < 2; s++) begin
            push({16'hEB90, 16'h0000, 32'(s)}, 1'b0);
            for (int j = 0; j < SW - 1; j++) begin
                int w;
                w = s * (SW - 1) + j;
                push({16'(4*w+1), 16'(4*w+2), 16'(4*w+3), 16'(4*w+4)}, j == SW - 2);
            end
        end
        start_session();
        check("hdr_busy", 64'(busy), 64'h1);
        for (int i = 1; i <= 8 * (SW - 1); i++) send(16'(i));
        tick();
        tick();
        check("hdr_sector_cnt", 64'(sector_cnt), 64'd2);
        check_drained("hdr");
`else
        // Continuous stream of 256 words: one full sector.
        for (int k = 0; k < SW; k++)
            push({16'(4*k+1), 16'(4*k+2), 16'(4*k+3), 16'(4*k+4)}, k == SW - 1);
        start_session();
        check("t1_busy", 64'(busy), 64'h1);
        for (int i = 1; i <= 4 * SW; i++) send(16'(i));
        tick();
        tick();
        check("t1_sector_cnt", 64'(sector_cnt), 64'd1);
        check("t1_ovf", 64'(ovf_flag), 64'h0);
        check("t1_busy_still", 64'(busy), 64'h1);
        check_drained("t1");
`endif

        // Reset mid-sector: a dropped word sets ovf, reset clears everything.
`ifdef CUT_PACK_HDR_EN
        push({16'hEB90, 16'h0000, 32'd2}, 1'b0);
`endif
        for (int i = 0; i < 7; i++) begin
            fifo_full = (i == 3);
            send(16'(16'h21 + i));
        end
        fifo_full = 1'b0;
        check("t5_ovf_before_reset", 64'(ovf_flag), 64'h1);
        reset_n = 1'b0;
        tick();
        check("t5_rst_wr_en", 64'(wr_en), 64'h0);
        check("t5_rst_wr_dat", wr_dat, 64'h0);
        check("t5_rst_sector_done", 64'(sector_done), 64'h0);
        check("t5_rst_sector_cnt", 64'(sector_cnt), 64'h0);
        check("t5_rst_ovf", 64'(ovf_flag), 64'h0);
        check("t5_rst_busy", 64'(busy), 64'h0);
        check_drained("t5_pre");
        reset_n = 1'b1;
        tick();
        start_session();
`ifdef CUT_PACK_HDR_EN
        push({16'hEB90, 16'h0000, 32'd0}, 1'b0);
        push(64'h0100_0101_0102_0103, 1'b0);
        push_pads(SW - 2);
`else
        push(64'h0100_0101_0102_0103, 1'b0);
        push_pads(SW - 1);
`endif
        for (int i = 0; i < 4; i++) send(16'(16'h100 + i));
        stop_session();
        wait_flush_done("t5", 1'b0);
        check("t5_sector_cnt", 64'(sector_cnt), 64'd1);
        check_drained("t5");

`ifndef CUT_PACK_HDR_EN
        // Partial word then stop: lane padding followed by whole pad words.
        push(64'h0001_0002_0003_0004, 1'b0);
        push(64'h0005_0006_FFFF_FFFF, 1'b0);
        push_pads(SW - 2);
        start_session();
        for (int i = 1; i <= 6; i++) send(16'(i));
        stop_session();
        wait_flush_done("t2", 1'b0);
        check("t2_sector_cnt", 64'(sector_cnt), 64'd1);
        check_drained("t2");

        // fifo_full on the 4th en_in of word 3: word dropped, flush tops the sector up.
        for (int k = 0; k < SW; k++)
            if (k != 2) push({16'(4*k+1), 16'(4*k+2), 16'(4*k+3), 16'(4*k+4)}, 1'b0);
        push_pads(1);
        start_session();
        for (int i = 1; i <= 4 * SW; i++) begin
            fifo_full = (i == 12);
            send(16'(i));
        end
        fifo_full = 1'b0;
        check("t3_ovf_set", 64'(ovf_flag), 64'h1);
        stop_session();
        wait_flush_done("t3", 1'b0);
        check("t3_ovf_sticky", 64'(ovf_flag), 64'h1);
        check("t3_sector_cnt", 64'(sector_cnt), 64'd1);
        check_drained("t3");

        // New start clears ovf; flush with fifo_full toggling loses no pad words.
        start_session();
        check("t4_ovf_cleared", 64'(ovf_flag), 64'h0);
        check("t4_sector_cnt_cleared", 64'(sector_cnt), 64'h0);
        push(64'h000A_000B_000C_000D, 1'b0);
        push(64'h000E_FFFF_FFFF_FFFF, 1'b0);
        push_pads(SW - 2);
        for (int i = 0; i < 5; i++) send(16'(16'hA + i));
        stop_session();
        wait_flush_done("t4", 1'b1);
        check("t4_sector_cnt", 64'(sector_cnt), 64'd1);
        check("t4_ovf", 64'(ovf_flag), 64'h0);
        check_drained("t4");
`endif

        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
